sram_like_slave: RTL and testbench
==================================

// Module: sram_like_slave
// PURPOSE
//  Responder end of the sram-like bus (req/wr/size/wstrb/addr/wdata -> addr_ok/data_ok/rdata) used by the fetch and memory stages.
//  Bridges that bus to a synchronous 1-cycle-read SRAM macro and returns responses strictly in order.
//  Supports up to MAX_OUTSTANDING accepted-but-unanswered requests.
//  Optional LFSR-driven stalls on addr_ok/data_ok exercise initiator handshake logic in SoC simulation.
// PARAMETERS
//  MEM_AW          14        word-address width of backing SRAM (bytes = 4<<MEM_AW)
//  MAX_OUTSTANDING 2         max accepted requests without data_ok (>=1)
//  RAND_STALL      0         1: enable pseudo-random stalls on addr_ok and data_ok
//  LFSR_SEED       16'hACE1  reset value of stall LFSR (must be non-zero)
// PORTS
//  clk        in   1        clock; all state updates on posedge
//  reset      in   1        synchronous, active-high reset
//  req        in   1        request valid from initiator
//  wr         in   1        1 = write, 0 = read
//  size       in   2        0 byte, 1 half, 2 word; informational, wstrb governs writes
//  wstrb      in   4        byte enables for writes
//  addr       in   32       physical byte address
//  wdata      in   32       write data
//  addr_ok    out  1        request accepted this cycle
//  data_ok    out  1        response for oldest outstanding request this cycle
//  rdata      out  32       read data, valid with data_ok
//  ram_en     out  1        SRAM enable
//  ram_wen    out  4        SRAM byte write enables
//  ram_addr   out  MEM_AW   SRAM word address = addr[MEM_AW+1:2]
//  ram_wdata  out  32       SRAM write data
//  ram_rdata  in   32       SRAM read data, valid the cycle after ram_en
// BEHAVIOUR
//  Reset: addr_ok=0, data_ok=0, rdata=0, ram_en=0, ram_wen=0. Count=0, pend_valid=0, response FIFO empty, lfsr=LFSR_SEED.
//  Stall: 16-bit Fibonacci LFSR, taps 16,14,13,11, shifts every cycle.
//    stall_a = RAND_STALL & lfsr[0]; stall_d = RAND_STALL & lfsr[1].
//  Acceptance: addr_ok = ~reset & req & (count != MAX_OUTSTANDING) & ~stall_a. Combinational; no path from data_ok.
//    Handshake is req & addr_ok. Inputs are sampled only on that cycle.
//    Initiator may drop or change req while addr_ok=0; the slave keeps no state for unaccepted requests.
//  Issue: in the handshake cycle T, ram_en=1, ram_addr=addr[MEM_AW+1:2], ram_wdata=wdata, ram_wen = wr ? wstrb : 4'b0.
//    A write commits at the end of T. Outside a handshake, ram_en=0 and ram_wen=0.
//    Addresses above the SRAM range alias by truncation; no error response.
//  Pipe: pend_valid/pend_wr are registered at end of T.
//    In T+1, push {pend_wr, pend_wr ? 32'b0 : ram_rdata} into a MAX_OUTSTANDING-deep FIFO.
//  Response: data_ok = ~reset & fifo_nonempty & ~stall_d; rdata = data_ok ? head.data : 32'b0. Pop on data_ok.
//    Earliest data_ok is T+2. Writes also receive data_ok, with rdata=0. Order is strictly FIFO.
//  Count: +1 on handshake, -1 on data_ok, unchanged when both occur in the same cycle.
//    Full is evaluated from registered count only.
//    FIFO occupancy + pend_valid <= count <= MAX_OUTSTANDING, so the FIFO cannot overflow.
//  Read-after-write to the same word in consecutive handshakes returns the new data (SRAM write-first across cycles).
//  Reset mid-operation: all in-flight requests are discarded and no data_ok is issued for them after reset.
//    Already-committed SRAM writes persist.
// TESTING
//  1 RAND_STALL=0, mem[4]=32'h24020001, read addr 32'h10 at cycle 0 -> addr_ok cycle 0, ram_en cycle 0, data_ok cycle 2, rdata=32'h24020001.
//  2 mem[8]=32'h11223344, write addr 32'h20 wstrb 4'b0011 wdata 32'hAABBCCDD, then read 32'h20 -> write data_ok with rdata 0; read returns 32'h1122CCDD.
//  3 MAX_OUTSTANDING=2, req held for reads A,B,C from cycle 0 -> addr_ok cycles 0,1,3 (0 in cycle 2); data_ok cycles 2,3,5 in A,B,C order.
//  4 Two reads outstanding, reset high 1 cycle -> addr_ok/data_ok 0 during reset; no data_ok afterwards; next read completes normally with latency 2.
//  5 Count=1, new handshake and data_ok in the same cycle -> count stays 1; next cycle addr_ok is still allowed.
//  6 RAND_STALL=1, 2000 random reads/writes with random req gaps vs. a scoreboard memory -> all data match, responses in order, outstanding never > MAX_OUTSTANDING.

Source files
------------

// File: rtl/sram_like_slave.sv
// In-order responder for the sram-like bus in front of a 1-cycle-read SRAM macro.
// Handshakes issue straight to the SRAM; responses queue in a small FIFO, with optional LFSR stalls.
module sram_like_slave #(
    parameter int          MEM_AW          = 14,
    parameter int          MAX_OUTSTANDING = 2,
    parameter bit          RAND_STALL      = 1'b0,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic [3:0]        wstrb,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              addr_ok,
    output logic              data_ok,
    output logic [31:0]       rdata,
    output logic              ram_en,
    output logic [3:0]        ram_wen,
    output logic [MEM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);

    logic [15:0]   lfsr_r;
    logic          stall_a_s;
    logic          stall_d_s;
    logic          hs_s;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic          pend_valid_r;
    logic          pend_wr_r;
    logic [31:0]   fifo_mem_r [MAX_OUTSTANDING];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] fifo_cnt_r;
    logic [CW-1:0] fifo_cnt_nxt_s;
    logic          fifo_push_s;
    logic          fifo_nonempty_s;
    logic [31:0]   push_data_s;
    logic          unused_s;

    // size is informational and the byte offset / upper address bits alias away
    assign unused_s = ^{size, addr[31:MEM_AW+2], addr[1:0]};

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        if (p == PTR_LAST) begin
            r = {PW{1'b0}};
        end else begin
            r = p + PW'(1);
        end
        return r;
    endfunction

    // Fibonacci LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Stall decode, acceptance and response valid; full comes only from the registered count
    always_comb begin
        stall_a_s       = RAND_STALL & lfsr_r[0];
        stall_d_s       = RAND_STALL & lfsr_r[1];
        addr_ok         = ~reset & req & (count_r != CNT_FULL) & ~stall_a_s;
        hs_s            = req & addr_ok;
        fifo_nonempty_s = (fifo_cnt_r != {CW{1'b0}});
        data_ok         = ~reset & fifo_nonempty_s & ~stall_d_s;
        if (data_ok) begin
            rdata = fifo_mem_r[rd_ptr_r];
        end else begin
            rdata = 32'h0000_0000;
        end
    end

    // SRAM issue happens in the handshake cycle itself
    always_comb begin
        ram_en    = hs_s;
        ram_addr  = addr[MEM_AW+1:2];
        ram_wdata = wdata;
        if (hs_s && wr) begin
            ram_wen = wstrb;
        end else begin
            ram_wen = 4'b0000;
        end
    end

    // Outstanding count: accepted but not yet answered
    always_comb begin
        count_nxt_s = count_r;
        case ({hs_s, data_ok})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Response capture one cycle after issue; writes respond with zero data
    always_comb begin
        fifo_push_s = pend_valid_r;
        if (pend_wr_r) begin
            push_data_s = 32'h0000_0000;
        end else begin
            push_data_s = ram_rdata;
        end
        fifo_cnt_nxt_s = fifo_cnt_r;
        case ({fifo_push_s, data_ok})
            2'b10:   fifo_cnt_nxt_s = fifo_cnt_r + CW'(1);
            2'b01:   fifo_cnt_nxt_s = fifo_cnt_r - CW'(1);
            default: fifo_cnt_nxt_s = fifo_cnt_r;
        endcase
    end

    // Control state; reset drops everything in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_r       <= LFSR_SEED;
            count_r      <= {CW{1'b0}};
            pend_valid_r <= 1'b0;
            pend_wr_r    <= 1'b0;
            wr_ptr_r     <= {PW{1'b0}};
            rd_ptr_r     <= {PW{1'b0}};
            fifo_cnt_r   <= {CW{1'b0}};
        end else begin
            lfsr_r       <= lfsr_step(lfsr_r);
            count_r      <= count_nxt_s;
            pend_valid_r <= hs_s;
            pend_wr_r    <= hs_s & wr;
            fifo_cnt_r   <= fifo_cnt_nxt_s;
            if (fifo_push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (data_ok) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Response FIFO storage; contents are qualified by fifo_cnt_r so no reset is needed
    always_ff @(posedge clk) begin
        if (fifo_push_s) begin
            fifo_mem_r[wr_ptr_r] <= push_data_s;
        end
    end

endmodule

// File: tb/tb_sram_like_slave.sv
// Bench for sram_like_slave: one instance without stalls for cycle-exact directed checks,
// one with random stalls; a transaction-level model checks both every cycle.
module tb_sram_like_slave;

    localparam int          AW    = 6;
    localparam int          MAXO  = 2;
    localparam int          WORDS = 1 << AW;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic          addr_ok   [2];
    logic          data_ok   [2];
    logic [31:0]   rdata     [2];
    logic          ram_en    [2];
    logic [3:0]    ram_wen   [2];
    logic [AW-1:0] ram_addr  [2];
    logic [31:0]   ram_wdata [2];
    logic [31:0]   ram_rdata [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sram_like_slave #(.MEM_AW(AW), .MAX_OUTSTANDING(MAXO), .RAND_STALL(1'b0), .LFSR_SEED(SEED)) u_dut (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .addr_ok(addr_ok[0]), .data_ok(data_ok[0]), .rdata(rdata[0]),
        .ram_en(ram_en[0]), .ram_wen(ram_wen[0]), .ram_addr(ram_addr[0]),
        .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata[0])
    );

    sram_like_slave #(.MEM_AW(AW), .MAX_OUTSTANDING(MAXO), .RAND_STALL(1'b1), .LFSR_SEED(SEED)) u_dut_rs (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .addr_ok(addr_ok[1]), .data_ok(data_ok[1]), .rdata(rdata[1]),
        .ram_en(ram_en[1]), .ram_wen(ram_wen[1]), .ram_addr(ram_addr[1]),
        .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata[1])
    );

    function automatic logic [31:0] init_word(input int w);
        if (w == 4) return 32'h2402_0001;
        else if (w == 8) return 32'h1122_3344;
        else return 32'hC0DE_0000 | 32'(w);
    endfunction

    // SRAM macros: byte-write, registered read
    logic [31:0] sram [2][WORDS];
    bit          sram_init = 1'b0;
    always @(posedge clk) begin
        if (!sram_init) begin
            for (int i = 0; i < 2; i++)
                for (int w = 0; w < WORDS; w++)
                    sram[i][w] <= init_word(w);
            sram_init <= 1'b1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (ram_en[i]) begin
                    for (int b = 0; b < 4; b++)
                        if (ram_wen[i][b]) sram[i][ram_addr[i]][8*b +: 8] <= ram_wdata[i][8*b +: 8];
                    ram_rdata[i] <= sram[i][ram_addr[i]];
                end
            end
        end
    end

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk32(nm, {31'b0, act}, {31'b0, exp});
    endtask

    // Transaction-level model: scoreboard memory, queue of pending responses with ready time
    logic [31:0] smem   [2][WORDS];
    logic [31:0] q_data [2][8];
    int          q_rdy  [2][8];
    int          q_head [2];
    int          q_n    [2];
    int          m_cnt  [2];
    int          m_obs  [2];
    logic [15:0] m_lfsr [2];
    int          cyc = 0;

    initial begin : cmp
        logic        e_aok, e_dok, st_a, st_d;
        logic [31:0] e_rdata;
        logic [3:0]  e_wen;
        int          widx, tl;
        for (int i = 0; i < 2; i++) begin
            for (int w = 0; w < WORDS; w++) smem[i][w] = init_word(w);
            q_head[i] = 0; q_n[i] = 0; m_cnt[i] = 0; m_obs[i] = 0; m_lfsr[i] = SEED;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                st_a = (i == 1) && m_lfsr[i][0];
                st_d = (i == 1) && m_lfsr[i][1];
                if (reset) begin
                    e_aok = 1'b0;
                    e_dok = 1'b0;
                end else begin
                    e_aok = req && (m_cnt[i] < MAXO) && !st_a;
                    e_dok = (q_n[i] > 0) && (q_rdy[i][q_head[i]] <= cyc) && !st_d;
                end
                e_rdata = e_dok ? q_data[i][q_head[i]] : 32'h0;
                e_wen   = (e_aok && wr) ? wstrb : 4'h0;
                chk1($sformatf("addr_ok[%0d]", i), addr_ok[i], e_aok);
                chk1($sformatf("data_ok[%0d]", i), data_ok[i], e_dok);
                chk32($sformatf("rdata[%0d]", i), rdata[i], e_rdata);
                chk1($sformatf("ram_en[%0d]", i), ram_en[i], e_aok);
                chk32($sformatf("ram_wen[%0d]", i), 32'(ram_wen[i]), 32'(e_wen));
                if (e_aok) begin
                    chk32($sformatf("ram_addr[%0d]", i), 32'(ram_addr[i]), 32'(addr[AW+1:2]));
                    chk32($sformatf("ram_wdata[%0d]", i), ram_wdata[i], wdata);
                end
                if (reset) m_obs[i] = 0;
                else m_obs[i] = m_obs[i] + int'(addr_ok[i]) - int'(data_ok[i]);
                chk1($sformatf("outstanding_le_max[%0d]", i), (m_obs[i] <= MAXO), 1'b1);
                if (reset) begin
                    m_cnt[i] = 0; q_n[i] = 0; m_lfsr[i] = SEED;
                end else begin
                    if (e_dok) begin
                        q_head[i] = (q_head[i] + 1) % 8; q_n[i]--; m_cnt[i]--;
                    end
                    if (e_aok) begin
                        widx = int'(addr[AW+1:2]);
                        tl = (q_head[i] + q_n[i]) % 8;
                        q_data[i][tl] = wr ? 32'h0 : smem[i][widx];
                        q_rdy[i][tl]  = cyc + 2;
                        q_n[i]++; m_cnt[i]++;
                        if (wr)
                            for (int b = 0; b < 4; b++)
                                if (wstrb[b]) smem[i][widx][8*b +: 8] = wdata[8*b +: 8];
                    end
                    m_lfsr[i] = {m_lfsr[i][14:0], m_lfsr[i][15] ^ m_lfsr[i][13] ^ m_lfsr[i][12] ^ m_lfsr[i][10]};
                end
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        req = r; wr = w; addr = a; wdata = d; wstrb = s; size = 2'd2;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (n) tick();
    endtask

    initial begin : stim
        logic [5:0]  ea, ed;
        logic [31:0] t3_addr [3];
        logic [31:0] t3_data [3];
        int          k, rk, wcnt;

        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Test 1: plain read, latency 2
        drive(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        @(negedge clk);
        chk1("t1_addr_ok", addr_ok[0], 1'b1);
        chk1("t1_ram_en", ram_en[0], 1'b1);
        chk32("t1_ram_addr", 32'(ram_addr[0]), 32'd4);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk1("t1_no_early_data_ok", data_ok[0], 1'b0);
        tick();
        @(negedge clk);
        chk1("t1_data_ok", data_ok[0], 1'b1);
        chk32("t1_rdata", rdata[0], 32'h2402_0001);
        tick();
        idle(6);

        // Test 2: partial write then read-after-write
        drive(1'b1, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0011);
        @(negedge clk);
        chk1("t2_wr_addr_ok", addr_ok[0], 1'b1);
        chk32("t2_ram_wen", 32'(ram_wen[0]), 32'h3);
        tick();
        drive(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        @(negedge clk);
        chk1("t2_rd_addr_ok", addr_ok[0], 1'b1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk1("t2_wr_data_ok", data_ok[0], 1'b1);
        chk32("t2_wr_rdata", rdata[0], 32'h0);
        tick();
        @(negedge clk);
        chk1("t2_rd_data_ok", data_ok[0], 1'b1);
        chk32("t2_rd_rdata", rdata[0], 32'h1122_CCDD);
        tick();
        idle(6);

        // Test 3: three reads with req held, outstanding limit 2
        ea = 6'b001011;
        ed = 6'b101100;
        t3_addr = '{32'h10, 32'h20, 32'h30};
        t3_data = '{32'h2402_0001, 32'h1122_CCDD, 32'hC0DE_000C};
        k = 0; rk = 0;
        for (int c = 0; c < 6; c++) begin
            if (k < 3) drive(1'b1, 1'b0, t3_addr[k], 32'h0, 4'h0);
            else drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            @(negedge clk);
            chk1($sformatf("t3_addr_ok_c%0d", c), addr_ok[0], ea[c]);
            chk1($sformatf("t3_data_ok_c%0d", c), data_ok[0], ed[c]);
            if (data_ok[0] && rk < 3) begin
                chk32($sformatf("t3_rdata_%0d", rk), rdata[0], t3_data[rk]);
                rk++;
            end
            if (addr_ok[0]) k++;
            tick();
        end
        chk32("t3_resp_count", 32'(rk), 32'd3);
        idle(6);

        // Test 5: handshake and data_ok in the same cycle keep count at 1
        drive(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        @(negedge clk);
        chk1("t5_c0_addr_ok", addr_ok[0], 1'b1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        drive(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        @(negedge clk);
        chk1("t5_c2_addr_ok", addr_ok[0], 1'b1);
        chk1("t5_c2_data_ok", data_ok[0], 1'b1);
        chk32("t5_c2_rdata", rdata[0], 32'h2402_0001);
        tick();
        drive(1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
        @(negedge clk);
        chk1("t5_c3_addr_ok", addr_ok[0], 1'b1);
        chk1("t5_c3_data_ok", data_ok[0], 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk32("t5_c4_rdata", rdata[0], 32'h1122_CCDD);
        tick();
        @(negedge clk);
        chk32("t5_c5_rdata", rdata[0], 32'hC0DE_000C);
        tick();
        idle(6);

        // Test 4: reset with two reads in flight
        drive(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        tick();
        drive(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        @(negedge clk);
        chk1("t4_second_addr_ok", addr_ok[0], 1'b1);
        tick();
        reset = 1'b1;
        drive(1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
        @(negedge clk);
        chk1("t4_rst_addr_ok", addr_ok[0], 1'b0);
        chk1("t4_rst_data_ok", data_ok[0], 1'b0);
        tick();
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk1($sformatf("t4_no_stale_data_ok_%0d", c), data_ok[0], 1'b0);
            tick();
        end
        drive(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        @(negedge clk);
        chk1("t4_post_addr_ok", addr_ok[0], 1'b1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk1("t4_post_early", data_ok[0], 1'b0);
        tick();
        @(negedge clk);
        chk1("t4_post_data_ok", data_ok[0], 1'b1);
        chk32("t4_post_rdata", rdata[0], 32'h2402_0001);
        tick();
        idle(6);

        // Test 6: random traffic; initiator changes requests freely while not accepted
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 9) < 6)
                drive(1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(1, 15)));
            else
                drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        wcnt = 0;
        while ((q_n[0] != 0 || q_n[1] != 0) && wcnt < 200) begin
            tick();
            wcnt++;
        end
        chk1("t6_drain_in_time", (q_n[0] == 0 && q_n[1] == 0), 1'b1);
        tick();
        @(negedge clk);
        #1;
        chk32("t6_all_answered_0", 32'(m_obs[0]), 32'd0);
        chk32("t6_all_answered_1", 32'(m_obs[1]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
